// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the register-file write-back path.
//   DATA_W / REG_N / ADDR_W : result width, register count, index width
//   wb_src_t                : identifies a write-back producer (ALU or MAC)
//   wb_req_t                : one pending result (destination + data)
//   other_src()             : the producer that is not the argument
// ----------------------------------------------------------------------------
package core_pkg;

   localparam int DATA_W = 128;
   localparam int REG_N  = 32;
   localparam int ADDR_W = 5;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MAC = 1'b1
   } wb_src_t;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   function automatic wb_src_t other_src(input wb_src_t s);
      return (s == SRC_ALU) ? SRC_MAC : SRC_ALU;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. Requester 0 is the ALU, requester 1 the
// MAC. Grants are combinational from the requests and the priority pointer.
// The pointer moves only when a grant is issued, so an idle cycle never
// changes who wins the next tie.
//   clk    : clock
//   rst    : asynchronous active-high reset (pointer favours the ALU)
//   req_i  : request per requester
//   gnt_o  : one-hot (or zero) grant, same cycle as req_i
// ----------------------------------------------------------------------------
module rr_arbiter2
   import core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // Source that wins the next tie.
   wb_src_t prio_q, prio_d;

   always_comb begin
      gnt_o  = 2'b00;
      prio_d = prio_q;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (prio_q == SRC_ALU) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      // Whoever was just granted goes to the back of the line.
      if (gnt_o[0])      prio_d = other_src(SRC_ALU);
      else if (gnt_o[1]) prio_d = other_src(SRC_MAC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prio_q <= SRC_ALU;
      else     prio_q <= prio_d;
   end

endmodule

// File: rtl/wb_arbiter_scoreboard.sv
// ----------------------------------------------------------------------------
// wb_arbiter_scoreboard
// Write-back arbiter and busy scoreboard for the 32 x 128-bit register file.
// Accepts results from the vector ALU and the MAC unit, grants at most one per
// cycle (round-robin on ties) and presents one registered write per cycle.
// A per-register busy bit is set when an instruction issues with that
// destination and cleared at the edge the register file captures its result.
//   clk, reset                   : clock, asynchronous active-high reset
//   alu_valid/ready/rd/data      : ALU result handshake
//   mac_valid/ready/rd/data      : MAC result handshake
//   issue_valid, issue_rd        : destination of the instruction issuing now
//   chk_rs1, chk_rs2, chk_rd     : hazard query indices
//   hazard                       : any queried register is busy
//   busy_vec                     : scoreboard bits (bit 0 always 0)
//   reg_write/write_reg/write_data : registered register-file write port
// ----------------------------------------------------------------------------
module wb_arbiter_scoreboard
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mac_valid,
   output logic              mac_ready,
   input  logic [ADDR_W-1:0] mac_rd,
   input  logic [DATA_W-1:0] mac_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   input  logic [ADDR_W-1:0] chk_rd,
   output logic              hazard,
   output logic [REG_N-1:0]  busy_vec,
   output logic              reg_write,
   output logic [ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0] write_data
);

   logic [1:0] gnt;
   wb_req_t    alu_req, mac_req, sel_req;

   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [REG_N-1:0]  busy_q, busy_d;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (reset),
      .req_i ({mac_valid, alu_valid}),
      .gnt_o (gnt)
   );

   assign alu_ready = gnt[0];
   assign mac_ready = gnt[1];

   assign alu_req = '{rd: alu_rd, data: alu_data};
   assign mac_req = '{rd: mac_rd, data: mac_data};
   assign sel_req = gnt[1] ? mac_req : alu_req;

   // Output register. A transfer to x0 completes the handshake but never
   // reaches the register file.
   always_comb begin
      wr_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if ((|gnt) && (sel_req.rd != '0)) begin
         wr_d    = 1'b1;
         wreg_d  = sel_req.rd;
         wdata_d = sel_req.data;
      end
   end

   // Scoreboard. Clear first, then set, so a same-edge issue to the register
   // being written leaves it busy for the newer instruction.
   always_comb begin
      busy_d = busy_q;
      if (wr_q)
         busy_d[wreg_q] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   // No bypass: a reader waits for busy to drop and reads the register file.
   assign hazard     = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
   assign busy_vec   = busy_q;
   assign reg_write  = wr_q;
   assign write_reg  = wreg_q;
   assign write_data = wdata_q;

endmodule

// File: doc/wb_arbiter_scoreboard.md
Name: wb_arbiter_scoreboard

Overview:
- Drives the write port of the 32 x 128-bit register file: accepts results from two producers, the vector ALU (single-cycle) and the MAC unit (multi-cycle).
- Grants at most one producer per cycle and presents one registered write to the register file per cycle.
- Keeps a per-register busy scoreboard so issue logic can stall on RAW/WAW hazards against in-flight results.

Parameters:
DATA_W, 128, width of result/write data
REG_N, 32, number of architectural registers
ADDR_W, 5, register index width (log2 REG_N)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result available
alu_ready  output  1  ALU result accepted this cycle (combinational grant)
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mac_valid  input  1  MAC result available
mac_ready  output  1  MAC result accepted this cycle (combinational grant)
mac_rd  input  ADDR_W  MAC destination register
mac_data  input  DATA_W  MAC result
issue_valid  input  1  instruction issued this cycle with a destination register
issue_rd  input  ADDR_W  destination of the issued instruction
chk_rs1  input  ADDR_W  hazard query, source 1
chk_rs2  input  ADDR_W  hazard query, source 2
chk_rd  input  ADDR_W  hazard query, destination (WAW)
hazard  output  1  query hits a busy register (combinational)
busy_vec  output  REG_N  current scoreboard bits
reg_write  output  1  register-file write enable (registered)
write_reg  output  ADDR_W  register-file write index (registered)
write_data  output  DATA_W  register-file write data (registered)

Behaviour:
- Reset, asynchronous:
  - reg_write=0, write_reg=0, write_data=0.
  - busy_vec=0.
  - Round-robin pointer = ALU.
  - Any unwritten captured result is discarded.
- Handshake:
  - A transfer occurs when valid&&ready.
  - ready depends only on the valids and the pointer; never on the ready of the other port.
  - The register file is always ready, so there is no backpressure from the output side.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the source not granted last; the pointer updates only on a grant.
  - Neither valid: no grant, pointer holds.
  - Producers must hold valid, rd and data stable until ready.
- Latency: a granted result at edge N appears on reg_write/write_reg/write_data for the cycle after edge N, i.e. the register file captures it at edge N+1.
  - reg_write is a one-cycle pulse per transfer.
  - Back-to-back grants produce back-to-back writes, so throughput is 1 write/cycle.
- rd==0: the handshake completes (ready=1), but reg_write stays 0 and there is no busy change.
- Scoreboard:
  - busy[i] is set at the edge where issue_valid&&issue_rd==i (i!=0).
  - busy[i] is cleared at the edge where reg_write&&write_reg==i, i.e. the same edge the register file captures the data.
  - Set and clear on the same index at the same edge: set wins, because the newer instruction is pending.
  - busy[0] is hardwired 0.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]. There is no bypass: a reader sees the new value via the register file's combinational read in the cycle after busy clears.
- The scoreboard does not track multiple in-flight writers to one register. Issue logic must stall on WAW using chk_rd.

Decomposition:
- Shared package core_pkg:
  - DATA_W, REG_N, ADDR_W constants.
  - wb_src_t enum {SRC_ALU, SRC_MAC}.
  - wb_req_t struct {rd, data}.
- One sub-module: rr_arbiter2, a 2-requester round-robin arbiter with grant-driven pointer update. The scoreboard and output register stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle while a MAC result is granted -> immediately reg_write=0, busy_vec=0; after release, first tie grants ALU.
- Single ALU: alu_valid=1, alu_rd=3, alu_data=0xA5..A5 -> alu_ready=1 same cycle; next cycle reg_write=1, write_reg=3, write_data=0xA5..A5; following cycle reg_write=0.
- Tie fairness: both valid for 4 cycles (alu_rd=1, mac_rd=2) -> grants ALU, MAC, ALU, MAC; writes to 1,2,1,2 on consecutive cycles.
- Scoreboard: issue_rd=5 -> busy_vec[5]=1, hazard=1 for chk_rs1=5. MAC writes rd=5 -> busy[5] clears at the write edge, hazard=0 next cycle.
- Set-wins: issue_rd=7 at the same edge reg_write writes register 7 -> busy[7] remains 1.
- x0: alu_rd=0 valid -> alu_ready=1, reg_write stays 0; issue_rd=0 -> busy_vec stays 0, hazard=0 for chk_rs1=0.
